// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command constants for the LCD frame sequencer.
// The optional power-on init sequence is enabled with LCD_INIT_SEQ_EN.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ROW0_ADDR,
    ST_ROW0_CHAR,
    ST_ROW1_ADDR,
    ST_ROW1_CHAR
  } seq_state_t;

  localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0E;
  localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_DDRAM_ROW0   = 8'h80;
  localparam logic [7:0] LCD_DDRAM_ROW1   = 8'hC0;

  // Maps a step of the power-on init sequence to its instruction byte
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_CMD_FUNC_SET;
      2'd1:    return LCD_CMD_DISP_ON;
      2'd2:    return LCD_CMD_CLEAR;
      default: return LCD_CMD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_frame_ram.sv
// Two-row character buffer: 2*COLS bytes, one write port, one
// asynchronous read port, every entry reset to BLANK_CHAR.
module lcd_frame_ram
  import lcd_pkg::*;
#(
  parameter int         COLS       = 16,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic       wrow,
  input  logic [4:0] wcol,
  input  logic [7:0] wdata,
  input  logic       rrow,
  input  logic [4:0] rcol,
  output logic [7:0] rdata
);

  localparam int AW = $clog2(2 * COLS);

  logic [7:0] mem [2*COLS];

  // Row-major flattening: row 1 starts right after the last column of row 0
  function automatic logic [AW-1:0] flat_idx(input logic row, input logic [4:0] col);
    return AW'(row ? (COLS + int'(col)) : int'(col));
  endfunction

  // Storage array; reset re-blanks the whole frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2 * COLS; i++) mem[i] <= BLANK_CHAR;
    end else if (we) begin
      mem[flat_idx(wrow, wcol)] <= wdata;
    end
  end

  // Read is combinational so the sequencer registers the pre-write value
  always_comb begin
    rdata = mem[flat_idx(rrow, rcol)];
  end

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Streams a host-written 2-row text frame to the LCD write driver as
// (RS, data) words over valid/ready. Define LCD_INIT_SEQ_EN to emit the
// HD44780 init instructions once after reset before the first frame.
module lcd_frame_sequencer
  import lcd_pkg::*;
#(
  parameter int         COLS       = 16,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       wr_row,
  input  logic [4:0] wr_col,
  input  logic [7:0] wr_data,
  output logic       cmd_valid,
  output logic       cmd_rs,
  output logic [7:0] cmd_data,
  input  logic       cmd_ready,
  output logic       busy
);

  localparam logic [4:0] LAST_COL = 5'(COLS - 1);

  seq_state_t state;
  logic       dirty;
  logic [4:0] col;
  logic       wr_ok;
  logic       xfer;
  logic       rd_row;
  logic [4:0] rd_col;
  logic [7:0] rd_data;

  assign wr_ok = wr_en && (int'(wr_col) < COLS);
  assign xfer  = cmd_valid && cmd_ready;

  lcd_frame_ram #(
    .COLS       (COLS),
    .BLANK_CHAR (BLANK_CHAR)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .wrow  (wr_row),
    .wcol  (wr_col),
    .wdata (wr_data),
    .rrow  (rd_row),
    .rcol  (rd_col),
    .rdata (rd_data)
  );

  // Address of the character to load on the next transfer (clamped at the row end)
  always_comb begin
    rd_row = (state == ST_ROW1_ADDR) || (state == ST_ROW1_CHAR);
    rd_col = 5'd0;
    if (((state == ST_ROW0_CHAR) || (state == ST_ROW1_CHAR)) && (col != LAST_COL)) begin
      rd_col = col + 5'd1;
    end
  end

  // Sequencer FSM: walks address/characters of both rows, registers every output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef LCD_INIT_SEQ_EN
      state <= ST_INIT;
`else
      state <= ST_IDLE;
`endif
      dirty     <= 1'b1;
      col       <= 5'd0;
      cmd_valid <= 1'b0;
      cmd_rs    <= 1'b0;
      cmd_data  <= 8'h00;
      busy      <= 1'b0;
    end else begin
      case (state)
`ifdef LCD_INIT_SEQ_EN
        ST_INIT: begin
          if (!cmd_valid) begin
            cmd_valid <= 1'b1;
            busy      <= 1'b1;
            cmd_rs    <= 1'b0;
            cmd_data  <= init_cmd(col[1:0]);
          end else if (xfer) begin
            if (col[1:0] == 2'd3) begin
              cmd_valid <= 1'b0;
              busy      <= 1'b0;
              col       <= 5'd0;
              state     <= ST_IDLE;
            end else begin
              col      <= col + 5'd1;
              cmd_data <= init_cmd(col[1:0] + 2'd1);
            end
          end
        end
`endif
        ST_IDLE: begin
          if (dirty) begin
            dirty     <= 1'b0;
            busy      <= 1'b1;
            cmd_valid <= 1'b1;
            cmd_rs    <= 1'b0;
            cmd_data  <= LCD_DDRAM_ROW0;
            state     <= ST_ROW0_ADDR;
          end else begin
            cmd_valid <= 1'b0;
          end
        end
        ST_ROW0_ADDR: begin
          if (xfer) begin
            cmd_rs   <= 1'b1;
            cmd_data <= rd_data;
            col      <= 5'd0;
            state    <= ST_ROW0_CHAR;
          end
        end
        ST_ROW0_CHAR: begin
          if (xfer) begin
            if (col == LAST_COL) begin
              cmd_rs   <= 1'b0;
              cmd_data <= LCD_DDRAM_ROW1;
              state    <= ST_ROW1_ADDR;
            end else begin
              col      <= col + 5'd1;
              cmd_data <= rd_data;
            end
          end
        end
        ST_ROW1_ADDR: begin
          if (xfer) begin
            cmd_rs   <= 1'b1;
            cmd_data <= rd_data;
            col      <= 5'd0;
            state    <= ST_ROW1_CHAR;
          end
        end
        ST_ROW1_CHAR: begin
          if (xfer) begin
            if (col == LAST_COL) begin
              cmd_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              col      <= col + 5'd1;
              cmd_data <= rd_data;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A host write always wins over the IDLE clear of dirty
      if (wr_ok) dirty <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Randomised self-checking bench for lcd_frame_sequencer with a
// frame-position reference model. Honours LCD_INIT_SEQ_EN when defined.
module tb_lcd_frame_sequencer;

  localparam int         COLS  = 16;
  localparam logic [7:0] BLANK = 8'h20;
`ifdef LCD_INIT_SEQ_EN
  localparam int INIT_WORDS = 4;
`else
  localparam int INIT_WORDS = 0;
`endif
  localparam int FRAME_WORDS = 2 * COLS + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic       wr_row;
  logic [4:0] wr_col;
  logic [7:0] wr_data;
  logic       cmd_valid;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       busy;

  int compare_count  = 0;
  int mismatch_count = 0;

  // Reference model state
  logic [7:0] shadow [2][COLS];
  logic       m_dirty;
  logic       m_active;
  int         m_pos;
  logic       m_valid;
  logic       m_busy;
  logic [8:0] m_word;
  logic       m_init_active;
  int         m_ipos;
  logic [7:0] init_tab [4] = '{8'h38, 8'h0E, 8'h01, 8'h06};

  logic [8:0] xfer_log [$];

  lcd_frame_sequencer #(.COLS(COLS), .BLANK_CHAR(BLANK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .cmd_valid (cmd_valid),
    .cmd_rs    (cmd_rs),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .busy      (busy)
  );

  // 50 MHz clock
  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compare_count++;
    if (obs !== exp) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic row, input logic [4:0] col,
                               input logic [7:0] d, input logic rdy);
    wr_en     = we;
    wr_row    = row;
    wr_col    = col;
    wr_data   = d;
    cmd_ready = rdy;
  endtask

  // Word p of a refresh: address, row-0 characters, address, row-1 characters
  function automatic logic [8:0] word_at(input int p);
    if (p == 0)         return {1'b0, 8'h80};
    if (p <= COLS)      return {1'b1, shadow[0][p-1]};
    if (p == COLS + 1)  return {1'b0, 8'hC0};
    return {1'b1, shadow[1][p-COLS-2]};
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < COLS; c++) shadow[r][c] = BLANK;
    m_dirty  = 1'b1;
    m_active = 1'b0;
    m_pos    = 0;
    m_valid  = 1'b0;
    m_busy   = 1'b0;
    m_word   = '0;
    m_ipos   = 0;
`ifdef LCD_INIT_SEQ_EN
    m_init_active = 1'b1;
`else
    m_init_active = 1'b0;
`endif
  endtask

  // Predict outputs after the coming edge; characters are sampled before this edge's write
  task automatic modelStep();
    logic xf;
    xf = m_valid && cmd_ready;
    if (m_init_active) begin
      if (!m_valid) begin
        m_valid = 1'b1;
        m_busy  = 1'b1;
        m_word  = {1'b0, init_tab[m_ipos]};
      end else if (xf) begin
        if (m_ipos == 3) begin
          m_valid = 1'b0;
          m_busy  = 1'b0;
          m_init_active = 1'b0;
        end else begin
          m_ipos++;
          m_word = {1'b0, init_tab[m_ipos]};
        end
      end
    end else if (!m_active) begin
      if (m_dirty) begin
        m_dirty  = 1'b0;
        m_active = 1'b1;
        m_pos    = 0;
        m_valid  = 1'b1;
        m_busy   = 1'b1;
        m_word   = word_at(0);
      end
    end else if (xf) begin
      if (m_pos == FRAME_WORDS - 1) begin
        m_valid  = 1'b0;
        m_busy   = 1'b0;
        m_active = 1'b0;
      end else begin
        m_pos++;
        m_word = word_at(m_pos);
      end
    end
    if (wr_en && int'(wr_col) < COLS) begin
      shadow[wr_row][wr_col] = wr_data;
      m_dirty = 1'b1;
    end
  endtask

  // One clock: drive at negedge, predict, then compare at the following negedge
  task automatic stepCycle(input logic we, input logic row, input logic [4:0] col,
                           input logic [7:0] d, input logic rdy);
    applyStimulus(we, row, col, d, rdy);
    if (cmd_valid && cmd_ready) xfer_log.push_back({cmd_rs, cmd_data});
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput("cmd_valid", 32'(cmd_valid), 32'(m_valid));
    checkOutput("busy", 32'(busy), 32'(m_busy));
    if (m_valid) begin
      checkOutput("cmd_rs", 32'(cmd_rs), 32'(m_word[8]));
      checkOutput("cmd_data", 32'(cmd_data), 32'(m_word[7:0]));
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) stepCycle(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
  endtask

  // Main test sequence
  initial begin
    logic collided;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 32'(cmd_valid), 32'd0);
    checkOutput("rst_rs", 32'(cmd_rs), 32'd0);
    checkOutput("rst_data", 32'(cmd_data), 32'h00);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    model_reset();
    rst_n = 1'b1;

    // Blank frame after reset
    xfer_log.delete();
    idle_cycles(INIT_WORDS + FRAME_WORDS + 8);
    checkOutput("frame0_len", 32'(xfer_log.size()), 32'(INIT_WORDS + FRAME_WORDS));
`ifdef LCD_INIT_SEQ_EN
    checkOutput("init_first", 32'(xfer_log[0]), {23'd0, 1'b0, 8'h38});
    checkOutput("init_last", 32'(xfer_log[3]), {23'd0, 1'b0, 8'h06});
`endif
    checkOutput("frame0_row0_addr", 32'(xfer_log[INIT_WORDS]), {23'd0, 1'b0, 8'h80});
    checkOutput("frame0_first_char", 32'(xfer_log[INIT_WORDS + 1]), {23'd0, 1'b1, 8'h20});
    checkOutput("frame0_row1_addr", 32'(xfer_log[INIT_WORDS + COLS + 1]), {23'd0, 1'b0, 8'hC0});
    checkOutput("frame0_last_char", 32'(xfer_log[INIT_WORDS + FRAME_WORDS - 1]), {23'd0, 1'b1, 8'h20});

    // Single write while idle: valid appears two edges after the write
    xfer_log.delete();
    stepCycle(1'b1, 1'b1, 5'd3, 8'h41, 1'b1);
    checkOutput("launch_lat_1", 32'(cmd_valid), 32'd0);
    stepCycle(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
    checkOutput("launch_lat_2", 32'(cmd_valid), 32'd1);
    idle_cycles(FRAME_WORDS + 6);
    checkOutput("frame1_len", 32'(xfer_log.size()), 32'(FRAME_WORDS));
    checkOutput("row1_col3", 32'(xfer_log[COLS + 5]), {23'd0, 1'b1, 8'h41});

    // Write to an entry on the very edge it is loaded
    xfer_log.delete();
    collided = 1'b0;
    stepCycle(1'b1, 1'b1, 5'd0, 8'h42, 1'b1);
    for (int i = 0; i < 2 * FRAME_WORDS + 8; i++) begin
      if (!collided && m_active && m_valid && m_pos == 5) begin
        collided = 1'b1;
        stepCycle(1'b1, 1'b0, 5'd5, 8'h5A, 1'b1);
      end else begin
        stepCycle(1'b0, 1'b0, 5'd0, 8'h00, 1'b1);
      end
    end
    checkOutput("collide_len", 32'(xfer_log.size()), 32'(2 * FRAME_WORDS));
    checkOutput("collide_old", 32'(xfer_log[6]), {23'd0, 1'b1, 8'h20});
    checkOutput("collide_new", 32'(xfer_log[FRAME_WORDS + 6]), {23'd0, 1'b1, 8'h5A});

    // Out-of-range column is ignored
    xfer_log.delete();
    stepCycle(1'b1, 1'b0, 5'd20, 8'h55, 1'b1);
    idle_cycles(20);
    checkOutput("illegal_wr_no_refresh", 32'(xfer_log.size()), 32'd0);

    // Random writes and 30% ready stalls
    for (int i = 0; i < 1500; i++) begin
      stepCycle(($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                8'($urandom), ($urandom_range(0, 99) >= 30) ? 1'b1 : 1'b0);
    end
    idle_cycles(FRAME_WORDS + 6);

    // Asynchronous reset in the middle of a refresh
    stepCycle(1'b1, 1'b0, 5'd1, 8'h77, 1'b1);
    for (int i = 0; i < 40 && !(m_active && m_pos >= 10); i++) idle_cycles(1);
    checkOutput("pre_reset_valid", 32'(cmd_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(cmd_valid), 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_data", 32'(cmd_data), 32'h00);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    xfer_log.delete();
    idle_cycles(INIT_WORDS + FRAME_WORDS + 6);
    checkOutput("restart_len", 32'(xfer_log.size()), 32'(INIT_WORDS + FRAME_WORDS));
    checkOutput("restart_first", 32'(xfer_log[0]),
                (INIT_WORDS != 0) ? {23'd0, 1'b0, 8'h38} : {23'd0, 1'b0, 8'h80});
    checkOutput("restart_reblank", 32'(xfer_log[INIT_WORDS + 2]), {23'd0, 1'b1, 8'h20});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
